// File: rtl/sorted_vec_serializer.sv
// sorted_vec_serializer: buffers sorted vectors and streams the first K elements of each, one per cycle.
// sign_ctrl captured with each vector selects ascending or descending index order.
module sorted_vec_serializer #(
    parameter int DATAWIDTH  = 8,
    parameter int DATALENGTH = 4,
    parameter int K          = 4,
    parameter int DEPTH      = 2
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic                          sign_ctrl_i,
    input  logic [DATAWIDTH-1:0]          x_i [DATALENGTH-1:0],
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DATAWIDTH-1:0]          y_o,
    output logic [$clog2(DATALENGTH)-1:0] idx_o,
    output logic                          last_o,
    output logic [$clog2(DEPTH):0]        level_o
);
    localparam int IW = $clog2(DATALENGTH);
    localparam int CW = K > 1 ? $clog2(K) : 1;
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t               state_q, state_n;
    logic [DATAWIDTH-1:0] mem [DEPTH-1:0][DATALENGTH-1:0];
    logic [DEPTH-1:0]     sign_mem;
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        level_q;
    logic [CW-1:0]        c_q;
    logic                 rdy_q, push, pop, hs, last_c, last_h;
    logic [IW-1:0]        idx_c, idx_h;
    logic [DATAWIDTH-1:0] y_c, y_h;

    // in_ready is purely state-based, so a full buffer never accepts on a same-cycle pop
    assign in_ready_o  = rdy_q && (level_q != LW'(DEPTH));
    assign push        = in_valid_i && in_ready_o;
    assign out_valid_o = (state_q == EMIT);
    assign hs          = out_valid_o && out_ready_i;
    assign last_c      = (c_q == CW'(K - 1));
    assign pop         = hs && last_c;
    assign idx_c       = sign_mem[rd_ptr] ? IW'(DATALENGTH - 1) - IW'(c_q) : IW'(c_q);
    assign y_c         = mem[rd_ptr][idx_c];
    assign y_o         = out_valid_o ? y_c : y_h;
    assign idx_o       = out_valid_o ? idx_c : idx_h;
    assign last_o      = out_valid_o ? last_c : last_h;
    assign level_o     = level_q;

    always_comb begin
        state_n = state_q;
        state_n = push ? EMIT : (pop && level_q == LW'(1)) ? IDLE : state_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            c_q     <= '0;
            y_h     <= '0;
            idx_h   <= '0;
            last_h  <= 1'b0;
        end else begin
            state_q <= state_n;
            rdy_q   <= 1'b1;
            level_q <= level_q + LW'(push) - LW'(pop);
            if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (hs) c_q <= last_c ? '0 : c_q + 1'b1;
            if (out_valid_o) begin
                y_h    <= y_c;
                idx_h  <= idx_c;
                last_h <= last_c;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr]      <= x_i;
            sign_mem[wr_ptr] <= sign_ctrl_i;
        end
    end
endmodule
